// File: rtl/dct_2d_sequencer.sv
// dct_2d_sequencer
// Drives one shared 1-D DCT butterfly through a full 8x8 2-D DCT:
// row pass -> transpose buffer -> column pass -> result buffer -> output rows.
//
// Ports
//   CLOCK, RESET          : single clock, synchronous active-high reset
//   IN_VALID/IN_READY     : row input handshake, IN_DATA holds samples 0..7
//   BF_DATA               : to butterfly DATA
//   BF_OUT                : from butterfly OUT_DATA (LATENCY cycles after BF_DATA)
//   OUT_VALID/OUT_READY   : coefficient row output handshake
//   OUT_DATA, OUT_LAST    : coefficient row r (cols 0..7), LAST on row 7
//   BUSY                  : a block is in flight
module dct_2d_sequencer #(
    parameter int LATENCY = 5,
    parameter int W       = 32
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic                IN_VALID,
    output logic                IN_READY,
    input  logic [7:0][W-1:0]   IN_DATA,
    output logic [7:0][W-1:0]   BF_DATA,
    input  logic [7:0][W-1:0]   BF_OUT,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic [7:0][W-1:0]   OUT_DATA,
    output logic                OUT_LAST,
    output logic                BUSY
);

    typedef enum logic [2:0] {
        ROW_FEED,
        ROW_DRAIN,
        COL_FEED,
        COL_DRAIN,
        OUT_SEND
    } state_e;

    // Travels alongside the butterfly data so the write-back knows where
    // (and whether) to store what comes out LATENCY cycles later.
    typedef struct packed {
        logic       vld;
        logic       col;   // 0: row pass, 1: column pass
        logic [2:0] idx;
    } tag_t;

    state_e                     state_q, state_d;
    logic [2:0]                 row_cnt_q, row_cnt_d;
    logic [2:0]                 col_cnt_q, col_cnt_d;
    logic [2:0]                 out_cnt_q, out_cnt_d;
    tag_t [LATENCY-1:0]         tag_q, tag_d;
    tag_t                       push_tag;
    tag_t                       tail;
    logic                       drain_done;
    logic [7:0][7:0][W-1:0]     tbuf_q, tbuf_d;
    logic [7:0][7:0][W-1:0]     rbuf_q, rbuf_d;

    assign tail = tag_q[LATENCY-1];

    // Drain is complete when, after this edge, nothing valid remains: every
    // entry that would shift forward is invalid (the tail drops out now).
    always_comb begin
        drain_done = 1'b1;
        for (int i = 0; i < LATENCY - 1; i++) begin
            if (tag_q[i].vld) drain_done = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        col_cnt_d = col_cnt_q;
        out_cnt_d = out_cnt_q;
        push_tag  = '0;
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
        OUT_LAST  = 1'b0;
        BF_DATA   = '0;
        OUT_DATA  = rbuf_q[out_cnt_q];
        case (state_q)
            ROW_FEED: begin
                IN_READY = 1'b1;
                BF_DATA  = IN_DATA;
                if (IN_VALID) begin
                    push_tag  = '{vld: 1'b1, col: 1'b0, idx: row_cnt_q};
                    row_cnt_d = row_cnt_q + 3'd1;
                    if (row_cnt_q == 3'd7) state_d = ROW_DRAIN;
                end
            end
            ROW_DRAIN: begin
                if (drain_done) state_d = COL_FEED;
            end
            COL_FEED: begin
                for (int k = 0; k < 8; k++) BF_DATA[k] = tbuf_q[k][col_cnt_q];
                push_tag  = '{vld: 1'b1, col: 1'b1, idx: col_cnt_q};
                col_cnt_d = col_cnt_q + 3'd1;
                if (col_cnt_q == 3'd7) state_d = COL_DRAIN;
            end
            COL_DRAIN: begin
                if (drain_done) state_d = OUT_SEND;
            end
            OUT_SEND: begin
                OUT_VALID = 1'b1;
                OUT_LAST  = (out_cnt_q == 3'd7);
                if (OUT_READY) begin
                    out_cnt_d = out_cnt_q + 3'd1;
                    if (out_cnt_q == 3'd7) state_d = ROW_FEED;
                end
            end
            default: state_d = ROW_FEED;
        endcase
    end

    assign BUSY = (state_q != ROW_FEED) || (row_cnt_q != 3'd0);

    always_comb begin
        tag_d    = tag_q;
        tag_d[0] = push_tag;
        for (int i = 1; i < LATENCY; i++) tag_d[i] = tag_q[i-1];
    end

    // Row results land transposed-ready in tbuf (row idx); column results
    // land in rbuf column idx, so rbuf rows are final coefficient rows.
    always_comb begin
        tbuf_d = tbuf_q;
        rbuf_d = rbuf_q;
        if (tail.vld && !tail.col) tbuf_d[tail.idx] = BF_OUT;
        if (tail.vld && tail.col) begin
            for (int k = 0; k < 8; k++) rbuf_d[k][tail.idx] = BF_OUT[k];
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q   <= ROW_FEED;
            row_cnt_q <= '0;
            col_cnt_q <= '0;
            out_cnt_q <= '0;
            tag_q     <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            col_cnt_q <= col_cnt_d;
            out_cnt_q <= out_cnt_d;
            tag_q     <= tag_d;
        end
    end

    // Buffers are never cleared; a reset cycle simply skips write-back.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            tbuf_q <= tbuf_d;
            rbuf_q <= rbuf_d;
        end
    end

endmodule

// File: tb/tb_dct_2d_sequencer.sv
// Bench for dct_2d_sequencer: a fixed-point 1-D DCT butterfly model with
// 5-cycle latency is attached to BF_DATA/BF_OUT. A block-level model
// (row DCT, transpose, column DCT) predicts every output row; a negedge
// compare process checks handshake signals and data every cycle.
module tb_dct_2d_sequencer;

    localparam int LAT = 5;
    localparam int W   = 32;

    typedef logic [7:0][W-1:0]      row_t;
    typedef logic [7:0][7:0][W-1:0] blk_t;

    logic CLOCK = 1'b0;
    logic RESET = 1'b1;
    logic IN_VALID = 1'b0;
    logic IN_READY;
    row_t IN_DATA = '0;
    row_t BF_DATA;
    row_t BF_OUT;
    logic OUT_VALID;
    logic OUT_READY = 1'b1;
    row_t OUT_DATA;
    logic OUT_LAST;
    logic BUSY;

    dct_2d_sequencer #(.LATENCY(LAT), .W(W)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
        .BF_DATA(BF_DATA), .BF_OUT(BF_OUT),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
        .OUT_LAST(OUT_LAST), .BUSY(BUSY)
    );

    always #5 CLOCK = ~CLOCK;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, $signed(got), $signed(exp));
    endtask

    // ---- butterfly model: orthonormal DCT-II, Q12 coefficients, floor ----
    function automatic int coef(input int k, input int n);
        int m;
        int s;
        int v;
        if (k == 0) return 1448;
        m = (k * (2 * n + 1)) % 32;
        s = 1;
        if (m > 16) m = 32 - m;
        if (m > 8) begin m = 16 - m; s = -1; end
        case (m)
            0: v = 2048; 1: v = 2009; 2: v = 1892; 3: v = 1703; 4: v = 1448;
            5: v = 1138; 6: v = 784;  7: v = 400;  default: v = 0;
        endcase
        return s * v;
    endfunction

    function automatic row_t bf1d(input row_t x);
        row_t   y;
        longint acc;
        for (int k = 0; k < 8; k++) begin
            acc = 0;
            for (int n = 0; n < 8; n++)
                acc += longint'(coef(k, n)) * longint'($signed(x[n]));
            y[k] = W'(acc >>> 12);
        end
        return y;
    endfunction

    function automatic blk_t model2d(input blk_t x);
        blk_t rr;
        blk_t o;
        row_t cv;
        row_t res;
        for (int r = 0; r < 8; r++) rr[r] = bf1d(x[r]);
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 8; k++) cv[k] = rr[k][c];
            res = bf1d(cv);
            for (int k = 0; k < 8; k++) o[k][c] = res[k];
        end
        return o;
    endfunction

    row_t bfp [LAT];
    assign BF_OUT = bfp[LAT-1];
    always @(posedge CLOCK) begin
        bfp[0] <= bf1d(BF_DATA);
        for (int i = 1; i < LAT; i++) bfp[i] <= bfp[i-1];
    end

    // ---- block-level model and per-cycle compare ----
    blk_t cur_blk, exp_blk;
    row_t got [8];
    row_t hold_data;
    logic hold_v = 1'b0;
    bit   pending = 1'b0;
    int   acc_rows = 0;
    int   since = 0;
    int   out_idx = 0;
    int   blocks_done = 0;
    int   lat_seen = -1;
    bit   lat_cap = 1'b0;
    int   row2_cycles = 0;
    bit   exp_ov;

    always @(negedge CLOCK) begin
        if (RESET) begin
            pending  = 1'b0;
            acc_rows = 0;
            since    = 0;
            out_idx  = 0;
            hold_v   = 1'b0;
        end else begin
            exp_ov = pending && (since >= 19);
            chk("in_ready", IN_READY, !pending);
            chk("busy", BUSY, pending || (acc_rows != 0));
            chk("out_valid", OUT_VALID, exp_ov);
            chk("out_last", OUT_LAST, exp_ov && (out_idx == 7));
            if (OUT_VALID && exp_ov) begin
                for (int c = 0; c < 8; c++)
                    chk($sformatf("out_data[%0d][%0d]", out_idx, c), OUT_DATA[c], exp_blk[out_idx][c]);
                if (hold_v) chk("hold_stable", OUT_DATA == hold_data, 1);
                if (!lat_cap && out_idx == 0) begin lat_seen = since; lat_cap = 1'b1; end
                if (out_idx == 2) row2_cycles++;
            end
            hold_v    = OUT_VALID && !OUT_READY;
            hold_data = OUT_DATA;
            if (IN_VALID && IN_READY) begin
                cur_blk[acc_rows] = IN_DATA;
                if (acc_rows == 7) begin
                    exp_blk  = model2d(cur_blk);
                    pending  = 1'b1;
                    since    = 0;
                    acc_rows = 0;
                    lat_cap  = 1'b0;
                end else acc_rows++;
            end
            if (OUT_VALID && OUT_READY && exp_ov) begin
                got[out_idx] = OUT_DATA;
                if (out_idx == 7) begin
                    out_idx = 0;
                    pending = 1'b0;
                    blocks_done++;
                end else out_idx++;
            end
            if (pending) since++;
        end
    end

    // ---- stimulus ----
    task automatic send_block(input blk_t b, input bit gaps, input bit hold);
        int  r = 0;
        int  t = 0;
        bit  ph = 1'b0;
        bit  acc;
        while (r < 8 && t < 300) begin
            if (gaps && ph) begin
                IN_VALID = 1'b0;
                for (int c = 0; c < 8; c++) IN_DATA[c] = 32'h0123_4000 + c;
            end else begin
                IN_VALID = 1'b1;
                IN_DATA  = b[r];
            end
            @(negedge CLOCK);
            acc = IN_VALID && IN_READY;
            @(posedge CLOCK); #1;
            if (acc) r++;
            ph = !ph;
            t++;
        end
        chk("send_timeout", r, 8);
        if (!hold) begin IN_VALID = 1'b0; IN_DATA = '0; end
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (blocks_done < target && t < 300) begin @(posedge CLOCK); t++; end
        chk("block_done", blocks_done >= target, 1);
    endtask

    task automatic check_const(input string nm, input int dc);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                chk($sformatf("%s[%0d][%0d]", nm, r, c), got[r][c], (r == 0 && c == 0) ? dc : 0);
    endtask

    blk_t b64, bzero, bramp;

    initial begin
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                b64[r][c]   = 64;
                bzero[r][c] = 0;
                bramp[r][c] = W'((r * 8 + c) * 3 - 50);
            end

        repeat (3) @(posedge CLOCK);
        #1 RESET = 1'b0;
        @(negedge CLOCK);
        chk("rst_in_ready", IN_READY, 1);
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_out_last", OUT_LAST, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_bf_data", BF_DATA == '0, 1);
        @(posedge CLOCK); #1;

        // constant 64, continuous
        send_block(b64, 1'b0, 1'b0);
        wait_done(1);
        check_const("c64", 511);
        chk("first_out_latency", lat_seen, 19);

        // all zero; idle afterwards
        send_block(bzero, 1'b0, 1'b0);
        wait_done(2);
        #1;
        chk("busy_idle", BUSY, 0);

        // constant 64 with IN_VALID toggling
        send_block(b64, 1'b1, 1'b0);
        wait_done(3);
        check_const("gap64", 511);

        // backpressure on row 2
        row2_cycles = 0;
        send_block(bramp, 1'b0, 1'b0);
        begin
            int t = 0;
            while (!(out_idx == 2 && pending) && t < 100) begin @(posedge CLOCK); #1; t++; end
        end
        OUT_READY = 1'b0;
        repeat (3) begin @(posedge CLOCK); #1; end
        OUT_READY = 1'b1;
        wait_done(4);
        chk("row2_held_cycles", row2_cycles, 4);

        // reset during COL_FEED with col_cnt = 4
        send_block(b64, 1'b0, 1'b0);
        repeat (9) begin @(posedge CLOCK); #1; end
        RESET = 1'b1;
        @(posedge CLOCK); #1;
        RESET = 1'b0;
        chk("midrst_in_ready", IN_READY, 1);
        chk("midrst_out_valid", OUT_VALID, 0);
        send_block(b64, 1'b0, 1'b0);
        wait_done(5);
        check_const("after_rst", 511);

        // back-to-back with IN_VALID held high
        send_block(b64, 1'b0, 1'b1);
        send_block(bzero, 1'b0, 1'b0);
        chk("b2b_first_dc", got[0][0], 511);
        wait_done(7);
        check_const("b2b_zero", 0);

        repeat (5) @(posedge CLOCK);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
